// File: rtl/axi_pkg.sv
// Shared definitions for the AXI4-Lite to native bridge: response codes,
// bridge FSM state encoding and response-code helper.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_RESP = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } bridge_state_e;

  function automatic logic [1:0] resp_of(input logic err);
    if (err) begin
      return RESP_SLVERR;
    end else begin
      return RESP_OKAY;
    end
  endfunction

endpackage

// File: rtl/axi_bridge_timer.sv
// Access timeout counter for the native request phase; expired_o flags the
// last wait cycle so the bridge can abort on the following edge.
module axi_bridge_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic run_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear on request entry, advance while waiting for ack.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (run_i && !ack_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // An ack in the expiry cycle wins, so expiry is masked by ack_i.
  assign expired_o = run_i && !ack_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/axi_lite_native_bridge.sv
// AXI4-Lite responder converting one transaction at a time into a native
// req/ack access. Optional access timeout: define AXI_BRIDGE_TIMEOUT_EN.
module axi_lite_native_bridge
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              arvalid_i,
  output logic              aready_o,
  input  logic [31:0]       araddr_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [31:0]       rdata_o,
  output logic [1:0]        rresp_o,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [31:0]       awaddr_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        wstrb_i,
  output logic              bvalid_o,
  input  logic              bready_i,
  output logic [1:0]        bresp_o,
  output logic              req_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       wdata_o,
  output logic [3:0]        wstrb_o,
  input  logic              ack_i,
  input  logic [31:0]       rdata_i,
  input  logic              err_i
);

  bridge_state_e     state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;

  logic              ar_hs_s;
  logic              aw_hs_s;
  logic              timer_start_s;
  logic              timeout_s;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^{araddr_i[31:ADDR_W], awaddr_i[31:ADDR_W]};

`ifdef AXI_BRIDGE_TIMEOUT_EN
  axi_bridge_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (timer_start_s),
    .run_i    (req_q),
    .ack_i    (ack_i),
    .expired_o(timeout_s)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0) ^ timer_start_s;
  assign timeout_s      = 1'b0;
`endif

  // Address-phase handshakes; read wins, AW and W only accepted together.
  always_comb begin
    ar_hs_s = 1'b0;
    aw_hs_s = 1'b0;
    if (state_q == IDLE) begin
      ar_hs_s = arvalid_i;
      aw_hs_s = !arvalid_i && awvalid_i && wvalid_i;
    end else begin
      ar_hs_s = 1'b0;
      aw_hs_s = 1'b0;
    end
  end

  assign aready_o  = ar_hs_s;
  assign awready_o = aw_hs_s;
  assign wready_o  = aw_hs_s;

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rvalid_d      = rvalid_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    timer_start_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (ar_hs_s) begin
          state_d       = RD_REQ;
          req_d         = 1'b1;
          we_d          = 1'b0;
          addr_d        = araddr_i[ADDR_W-1:0];
          timer_start_s = 1'b1;
        end else if (aw_hs_s) begin
          state_d       = WR_REQ;
          req_d         = 1'b1;
          we_d          = 1'b1;
          addr_d        = awaddr_i[ADDR_W-1:0];
          wdata_d       = wdata_i;
          wstrb_d       = wstrb_i;
          timer_start_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        if (ack_i) begin
          state_d  = RD_RESP;
          req_d    = 1'b0;
          rvalid_d = 1'b1;
          rdata_d  = rdata_i;
          rresp_d  = resp_of(err_i);
        end else if (timeout_s) begin
          state_d  = RD_RESP;
          req_d    = 1'b0;
          rvalid_d = 1'b1;
          rdata_d  = 32'h0000_0000;
          rresp_d  = RESP_SLVERR;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_RESP: begin
        if (rready_i) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
        end else begin
          state_d = RD_RESP;
        end
      end
      WR_REQ: begin
        if (ack_i) begin
          state_d  = WR_RESP;
          req_d    = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = resp_of(err_i);
        end else if (timeout_s) begin
          state_d  = WR_RESP;
          req_d    = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = RESP_SLVERR;
        end else begin
          state_d = WR_REQ;
        end
      end
      WR_RESP: begin
        if (bready_i) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
        end else begin
          state_d = WR_RESP;
        end
      end
      default: begin
        state_d  = IDLE;
        req_d    = 1'b0;
        rvalid_d = 1'b0;
        bvalid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any transaction in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'h0000_0000;
      wstrb_q  <= 4'h0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0000_0000;
      rresp_q  <= 2'b00;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
    end
  end

  assign req_o    = req_q;
  assign we_o     = we_q;
  assign addr_o   = addr_q;
  assign wdata_o  = wdata_q;
  assign wstrb_o  = wstrb_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign rresp_o  = rresp_q;
  assign bvalid_o = bvalid_q;
  assign bresp_o  = bresp_q;

endmodule
